col_decoder: RTL and testbench

COL_DECODER -- requirements
Module: col_decoder

---
 rtl/col_decoder.sv | 88 ++++++++
 tb/tb_col_decoder.sv | 104 ++++++++++
 2 files changed

// File: rtl/col_decoder.sv
// Column decoder for a CAM/MAC bit-cell array.
// Drives registered BL/BLB pairs: one-hot precharge in MAC mode, key/~key in CAM mode.
module col_decoder (
    input  logic clk,
    input  logic rst_n,
    input  logic MAC_en,
    input  logic addr0,
    input  logic addr1,
    input  logic addr2,
    input  logic data0,
    input  logic data1,
    input  logic data2,
    input  logic data3,
    input  logic data4,
    input  logic data5,
    input  logic data6,
    input  logic data7,
    output logic BL0,
    output logic BL1,
    output logic BL2,
    output logic BL3,
    output logic BL4,
    output logic BL5,
    output logic BL6,
    output logic BL7,
    output logic BLB0,
    output logic BLB1,
    output logic BLB2,
    output logic BLB3,
    output logic BLB4,
    output logic BLB5,
    output logic BLB6,
    output logic BLB7
);

    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] bl_d;
    logic [7:0] blb_d;
    logic [7:0] bl_q;
    logic [7:0] blb_q;

    assign addr = {addr2, addr1, addr0};
    assign data = {data7, data6, data5, data4,
                   data3, data2, data1, data0};

    // Next bit-line values: selected column both high in MAC, key and complement in CAM
    always_comb begin
        bl_d  = 8'h00;
        blb_d = 8'h00;
        if (MAC_en) begin
            bl_d[addr]  = 1'b1;
            blb_d[addr] = 1'b1;
        end else begin
            bl_d  = data;
            blb_d = ~data;
        end
    end

    // Output registers; reset forces every line low regardless of mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bl_q  <= 8'h00;
            blb_q <= 8'h00;
        end else begin
            bl_q  <= bl_d;
            blb_q <= blb_d;
        end
    end

    assign BL0  = bl_q[0];
    assign BL1  = bl_q[1];
    assign BL2  = bl_q[2];
    assign BL3  = bl_q[3];
    assign BL4  = bl_q[4];
    assign BL5  = bl_q[5];
    assign BL6  = bl_q[6];
    assign BL7  = bl_q[7];
    assign BLB0 = blb_q[0];
    assign BLB1 = blb_q[1];
    assign BLB2 = blb_q[2];
    assign BLB3 = blb_q[3];
    assign BLB4 = blb_q[4];
    assign BLB5 = blb_q[5];
    assign BLB6 = blb_q[6];
    assign BLB7 = blb_q[7];

endmodule

// File: tb/tb_col_decoder.sv
// Self-checking bench for col_decoder.
// Expected {BL,BLB} is queued when inputs are driven and popped after the edge.
module tb_col_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic MAC_en;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] bl;
    logic [7:0] blb;

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] sb_q[$];
    logic [15:0] last_exp;
    bit have_last = 1'b0;

    always #5 clk = ~clk;

    col_decoder dut (
        .clk(clk), .rst_n(rst_n), .MAC_en(MAC_en),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]),
        .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
        .data4(data[4]), .data5(data[5]), .data6(data[6]), .data7(data[7]),
        .BL0(bl[0]), .BL1(bl[1]), .BL2(bl[2]), .BL3(bl[3]),
        .BL4(bl[4]), .BL5(bl[5]), .BL6(bl[6]), .BL7(bl[7]),
        .BLB0(blb[0]), .BLB1(blb[1]), .BLB2(blb[2]), .BLB3(blb[3]),
        .BLB4(blb[4]), .BLB5(blb[5]), .BLB6(blb[6]), .BLB7(blb[7])
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got BL=%02h BLB=%02h, want BL=%02h BLB=%02h",
                      tag, got[15:8], got[7:0], exp[15:8], exp[7:0]);
    endtask

    function automatic logic [15:0] model(input logic r, input logic m,
                                          input logic [2:0] a,
                                          input logic [7:0] d);
        logic [7:0] oh;
        oh = 8'h01 << a;
        if (!r) return 16'h0000;
        if (m) return {oh, oh};
        return {d, ~d};
    endfunction

    // Drive one cycle of inputs, check hold before the edge, check result after
    task automatic step(input string tag, input logic r, input logic m,
                        input logic [2:0] a, input logic [7:0] d);
        logic [15:0] e;
        rst_n = r; MAC_en = m; addr = a; data = d;
        sb_q.push_back(model(r, m, a, d));
        #2;
        if (have_last) chk({tag, "_hold"}, {bl, blb}, last_exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'hxxxx, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {bl, blb}, e);
            last_exp = e;
            have_last = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; MAC_en = 1'b1; addr = 3'd2; data = 8'h00;
        @(negedge clk);
        step("rst0", 0, 1, 3'd2, 8'h00);
        step("rst1", 0, 1, 3'd2, 8'h00);
        chk("rst_const", {bl, blb}, 16'h0000);
        step("mac_a2", 1, 1, 3'd2, 8'h00);
        chk("mac_a2_const", {bl, blb}, 16'h0404);
        step("mac_a2_dff", 1, 1, 3'd2, 8'hFF);
        step("mac_a1", 1, 1, 3'd1, 8'hFF);
        chk("mac_a1_const", {bl, blb}, 16'h0202);
        for (int i = 0; i < 8; i++)
            step($sformatf("sweep%0d", i), 1, 1, 3'(i), 8'($urandom));
        step("cam_ff", 1, 0, 3'd5, 8'hFF);
        chk("cam_ff_const", {bl, blb}, 16'hFF00);
        step("cam_aa", 1, 0, 3'd1, 8'hAA);
        chk("cam_aa_const", {bl, blb}, 16'hAA55);
        step("cam_aa_a3", 1, 0, 3'd3, 8'hAA);
        step("sw_mac", 1, 1, 3'd7, 8'hAA);
        step("sw_cam", 1, 0, 3'd7, 8'h3C);
        step("rst_cam", 0, 0, 3'd4, 8'h5A);
        chk("rst_cam_const", {bl, blb}, 16'h0000);
        step("post_rst", 1, 0, 3'd4, 8'h5A);
        step("rst_mac", 0, 1, 3'd6, 8'h00);
        step("post_rst_mac", 1, 1, 3'd6, 8'h00);
        for (int i = 0; i < 24; i++)
            step($sformatf("rnd%0d", i), ($urandom_range(0, 7) != 0),
                 1'($urandom), 3'($urandom), 8'($urandom));
        if (sb_q.size() != 0)
            chk("sb_leftover", 16'(sb_q.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
